// File: rtl/ram1_bus_arbiter_pkg.sv
// Shared constants and types for the RAM1/COM1 bus arbiter.
//   RAM1_UPPER   : data addresses below this go to the RAM1 SRAM
//   COM1_DATA    : UART data register address
//   COM1_COMMAND : UART status register address
//   state_e      : bus sequencer states
//   dec_e        : data-port address classes, see decode_daddr()
package ram1_bus_arbiter_pkg;

  localparam logic [15:0] RAM1_UPPER   = 16'h8000;
  localparam logic [15:0] COM1_DATA    = 16'hBF00;
  localparam logic [15:0] COM1_COMMAND = 16'hBF01;

  typedef enum logic [2:0] {
    StIdle,
    StRd,
    StWrSetup,
    StWrPulse,
    StWrHold,
    StURd,
    StUWr,
    StDone
  } state_e;

  typedef enum logic [1:0] {
    DecSram,
    DecUart,
    DecStatus,
    DecNone
  } dec_e;

  function automatic dec_e decode_daddr(input logic [15:0] addr);
    if (addr < RAM1_UPPER) begin
      return DecSram;
    end else if (addr == COM1_DATA) begin
      return DecUart;
    end else if (addr == COM1_COMMAND) begin
      return DecStatus;
    end
    return DecNone;
  endfunction

endpackage

// File: rtl/ram1_bus_arbiter.sv
// Sequencer and arbiter for the shared RAM1 SRAM / COM1 UART bus.
// Data port has fixed priority over the fetch port; requests are sampled only in IDLE.
// Ports:
//   clk, rst                     clock, synchronous active-high reset
//   if_req/if_addr/if_rdata/if_ack   instruction-fetch port (SRAM read only)
//   d_req/d_we/d_addr/d_wdata/d_rdata/d_ack   data port (SRAM, UART data, UART status)
//   mem_conflict                 fetch pending but the bus is not serving it
//   Ram1Addr/Ram1Data/Ram1EN/Ram1OE/Ram1WE   SRAM pins (strobes active-low)
//   rdn/wrn                      UART strobes (active-low)
//   tbre/tsre/data_ready         UART status inputs
module ram1_bus_arbiter
  import ram1_bus_arbiter_pkg::*;
#(
  parameter int unsigned WR_PULSE   = 1,
  parameter int unsigned UART_PULSE = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [15:0] if_addr,
  output logic [15:0] if_rdata,
  output logic        if_ack,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [15:0] d_addr,
  input  logic [15:0] d_wdata,
  output logic [15:0] d_rdata,
  output logic        d_ack,
  output logic        mem_conflict,
  output logic [17:0] Ram1Addr,
  inout  wire  [15:0] Ram1Data,
  output logic        Ram1EN,
  output logic        Ram1OE,
  output logic        Ram1WE,
  output logic        rdn,
  output logic        wrn,
  input  logic        tbre,
  input  logic        tsre,
  input  logic        data_ready
);

  // Pulse counters hold pulse_length-1 at most; both pulses are limited to 1..4 cycles.
  localparam logic [1:0] WrLast   = 2'(WR_PULSE - 1);
  localparam logic [1:0] UartLast = 2'(UART_PULSE - 1);

  state_e      state_q, state_d;
  logic [1:0]  cnt_q, cnt_d;
  logic        grant_if_q, grant_if_d;
  logic [15:0] addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d;
  logic        drive_q, drive_d;
  logic [15:0] if_rdata_q, if_rdata_d;
  logic [15:0] d_rdata_q, d_rdata_d;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= StIdle;
      cnt_q      <= '0;
      grant_if_q <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      drive_q    <= 1'b0;
      if_rdata_q <= '0;
      d_rdata_q  <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      grant_if_q <= grant_if_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      drive_q    <= drive_d;
      if_rdata_q <= if_rdata_d;
      d_rdata_q  <= d_rdata_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    grant_if_d = grant_if_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    if_rdata_d = if_rdata_q;
    d_rdata_d  = d_rdata_q;

    unique case (state_q)
      StIdle: begin
        cnt_d = '0;
        if (d_req) begin
          grant_if_d = 1'b0;
          addr_d     = d_addr;
          case (decode_daddr(d_addr))
            DecSram: begin
              wdata_d = d_wdata;
              state_d = d_we ? StWrSetup : StRd;
            end
            DecUart: begin
              wdata_d = {8'h00, d_wdata[7:0]};
              state_d = d_we ? StUWr : StURd;
            end
            DecStatus: begin
              // Status is answered from the live UART flags; writes are ignored.
              if (!d_we) d_rdata_d = {14'b0, data_ready, tbre & tsre};
              state_d = StDone;
            end
            default: begin
              if (!d_we) d_rdata_d = '0;
              state_d = StDone;
            end
          endcase
        end else if (if_req) begin
          grant_if_d = 1'b1;
          addr_d     = if_addr;
          state_d    = StRd;
        end
      end
      StRd: begin
        if (grant_if_q) if_rdata_d = Ram1Data;
        else            d_rdata_d  = Ram1Data;
        state_d = StDone;
      end
      StWrSetup: begin
        state_d = StWrPulse;
      end
      StWrPulse: begin
        if (cnt_q == WrLast) state_d = StWrHold;
        else                 cnt_d   = cnt_q + 2'd1;
      end
      StWrHold: begin
        state_d = StDone;
      end
      StURd: begin
        if (cnt_q == UartLast) begin
          d_rdata_d = {8'h00, Ram1Data[7:0]};
          state_d   = StDone;
        end else begin
          cnt_d = cnt_q + 2'd1;
        end
      end
      StUWr: begin
        if (cnt_q == UartLast) state_d = StDone;
        else                   cnt_d   = cnt_q + 2'd1;
      end
      StDone: begin
        state_d = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase

    // Registered so the bus enable switches cleanly with the state.
    drive_d = (state_d == StWrSetup) || (state_d == StWrPulse) ||
              (state_d == StWrHold)  || (state_d == StUWr);
  end

  assign Ram1Data = drive_q ? wdata_q : 16'hzzzz;
  assign Ram1Addr = {2'b00, addr_q};

  // SRAM stays disabled in the UART states, which keeps the two devices exclusive.
  assign Ram1EN = !((state_q == StRd) || (state_q == StWrSetup) ||
                    (state_q == StWrPulse) || (state_q == StWrHold));
  assign Ram1OE = !(state_q == StRd);
  assign Ram1WE = !(state_q == StWrPulse);
  assign rdn    = !(state_q == StURd);
  assign wrn    = !(state_q == StUWr);

  assign if_ack   = (state_q == StDone) && grant_if_q;
  assign d_ack    = (state_q == StDone) && !grant_if_q;
  assign if_rdata = if_rdata_q;
  assign d_rdata  = d_rdata_q;

  assign mem_conflict = !rst && if_req && !(grant_if_q && (state_q != StIdle)) && !if_ack;

endmodule

// File: tb/tb_ram1_bus_arbiter.sv
// Self-checking bench for ram1_bus_arbiter: pin-level SRAM and UART models on the bus,
// directed scenarios followed by random transactions checked against an array model.
module tb_ram1_bus_arbiter;

  localparam int unsigned WrPulse   = 1;
  localparam int unsigned UartPulse = 2;
  localparam logic [15:0] Com1Data  = 16'hBF00;
  localparam logic [15:0] Com1Cmd   = 16'hBF01;
  localparam logic [15:0] SramTop   = ram1_bus_arbiter_pkg::RAM1_UPPER;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req, d_req, d_we, tbre, tsre, data_ready;
  logic [15:0] if_addr, d_addr, d_wdata, if_rdata, d_rdata;
  logic        if_ack, d_ack, mem_conflict;
  logic        Ram1EN, Ram1OE, Ram1WE, rdn, wrn;
  logic [17:0] Ram1Addr;
  wire  [15:0] Ram1Data;

  // Pin-level SRAM contents and the reference model's expected contents.
  logic [15:0] sram    [0:65535];
  logic [15:0] ref_mem [0:65535];
  logic [7:0]  uart_byte;

  int n_checks = 0;
  int n_fail   = 0;

  // Per-transaction bus monitors, cleared at the start of each access.
  logic [15:0] exp_bus;
  int we_low_n, wr_phase_n, wr_bus_bad, wrn_low_n, wrn_bus_bad, rdn_low_n, excl_bad;

  // Upper UART byte is junk so the bench can see that it is discarded.
  assign Ram1Data = (!Ram1EN && !Ram1OE && Ram1WE) ? sram[Ram1Addr[15:0]] :
                    (!rdn) ? {8'hC3, uart_byte} : 16'hzzzz;

  always #5 clk = ~clk;

  ram1_bus_arbiter #(
    .WR_PULSE  (WrPulse),
    .UART_PULSE(UartPulse)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .if_req      (if_req),
    .if_addr     (if_addr),
    .if_rdata    (if_rdata),
    .if_ack      (if_ack),
    .d_req       (d_req),
    .d_we        (d_we),
    .d_addr      (d_addr),
    .d_wdata     (d_wdata),
    .d_rdata     (d_rdata),
    .d_ack       (d_ack),
    .mem_conflict(mem_conflict),
    .Ram1Addr    (Ram1Addr),
    .Ram1Data    (Ram1Data),
    .Ram1EN      (Ram1EN),
    .Ram1OE      (Ram1OE),
    .Ram1WE      (Ram1WE),
    .rdn         (rdn),
    .wrn         (wrn),
    .tbre        (tbre),
    .tsre        (tsre),
    .data_ready  (data_ready)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Advance to the next falling edge, then sample the bus and play the SRAM write.
  task automatic tick();
    @(negedge clk);
    if (!Ram1EN && !Ram1WE) sram[Ram1Addr[15:0]] = Ram1Data;
    if (!Ram1WE) we_low_n++;
    if (!Ram1EN && Ram1OE) begin
      wr_phase_n++;
      if (Ram1Data !== exp_bus) wr_bus_bad++;
    end
    if (!wrn) begin
      wrn_low_n++;
      if (Ram1Data !== exp_bus) wrn_bus_bad++;
    end
    if (!rdn) rdn_low_n++;
    if ((!rdn || !wrn) && !Ram1EN) excl_bad++;
  endtask

  // One transaction, issued from an IDLE cycle; returns in the next IDLE cycle.
  task automatic access(input bit is_if, input bit we, input logic [15:0] addr,
                        input logic [15:0] wdata, input string tag);
    int          exp_lat, lat;
    logic [15:0] exp_rd;
    bit          is_read, sram_wr, uart_wr, uart_rd, got;

    exp_rd  = '0;
    sram_wr = 1'b0;
    uart_wr = 1'b0;
    uart_rd = 1'b0;
    exp_bus = 16'h0000;
    is_read = is_if || !we;
    if (is_if) begin
      exp_lat = 2;
      exp_rd  = ref_mem[addr];
    end else if (addr < SramTop) begin
      if (we) begin
        exp_lat       = int'(WrPulse) + 3;
        sram_wr       = 1'b1;
        exp_bus       = wdata;
        ref_mem[addr] = wdata;
      end else begin
        exp_lat = 2;
        exp_rd  = ref_mem[addr];
      end
    end else if (addr == Com1Data) begin
      exp_lat = int'(UartPulse) + 1;
      if (we) begin
        uart_wr = 1'b1;
        exp_bus = {8'h00, wdata[7:0]};
      end else begin
        uart_rd = 1'b1;
        exp_rd  = {8'h00, uart_byte};
      end
    end else if (addr == Com1Cmd) begin
      exp_lat = 1;
      exp_rd  = {14'b0, data_ready, tbre & tsre};
    end else begin
      exp_lat = 1;
      exp_rd  = 16'h0000;
    end

    we_low_n = 0; wr_phase_n = 0; wr_bus_bad = 0; wrn_low_n = 0;
    wrn_bus_bad = 0; rdn_low_n = 0; excl_bad = 0;

    if (is_if) begin
      if_req  = 1'b1;
      if_addr = addr;
    end else begin
      d_req   = 1'b1;
      d_we    = we;
      d_addr  = addr;
      d_wdata = wdata;
    end

    got = 1'b0;
    lat = 0;
    for (int k = 1; k <= 40 && !got; k++) begin
      tick();
      if (is_if ? if_ack : d_ack) begin
        got = 1'b1;
        lat = k;
      end
    end
    check($sformatf("%s_ack_seen", tag), 32'(got), 32'd1);
    check($sformatf("%s_latency", tag), 32'(lat), 32'(exp_lat));
    check($sformatf("%s_other_ack", tag), 32'(is_if ? d_ack : if_ack), 32'd0);
    if (is_read) begin
      check($sformatf("%s_rdata", tag), 32'(is_if ? if_rdata : d_rdata), 32'(exp_rd));
    end
    check($sformatf("%s_we_low", tag), 32'(we_low_n), sram_wr ? 32'(WrPulse) : 32'd0);
    check($sformatf("%s_wr_phase", tag), 32'(wr_phase_n), sram_wr ? 32'(WrPulse + 2) : 32'd0);
    check($sformatf("%s_wr_bus", tag), 32'(wr_bus_bad), 32'd0);
    check($sformatf("%s_wrn_low", tag), 32'(wrn_low_n), uart_wr ? 32'(UartPulse) : 32'd0);
    check($sformatf("%s_wrn_bus", tag), 32'(wrn_bus_bad), 32'd0);
    check($sformatf("%s_rdn_low", tag), 32'(rdn_low_n), uart_rd ? 32'(UartPulse) : 32'd0);
    check($sformatf("%s_exclusive", tag), 32'(excl_bad), 32'd0);

    if_req = 1'b0;
    d_req  = 1'b0;
    tick();
    check($sformatf("%s_ack_pulse", tag), {30'b0, if_ack, d_ack}, 32'd0);
    if (is_read) begin
      check($sformatf("%s_rdata_hold", tag), 32'(is_if ? if_rdata : d_rdata), 32'(exp_rd));
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [15:0] a, w;
    int          r;
    int          conf_bad;

    rst = 1'b1;
    if_req = 1'b1; if_addr = 16'h0000;
    d_req = 1'b0; d_we = 1'b0; d_addr = 16'h0000; d_wdata = 16'h0000;
    tbre = 1'b0; tsre = 1'b0; data_ready = 1'b0; uart_byte = 8'h00;
    exp_bus = 16'h0000;
    for (int i = 0; i < 65536; i++) begin
      sram[i]    = 16'(i * 40503 + 17);
      ref_mem[i] = 16'(i * 40503 + 17);
    end
    sram[16'h0040]    = 16'h1234;
    ref_mem[16'h0040] = 16'h1234;

    // Reset state, with a fetch request held high to show mem_conflict is masked.
    tick(); tick(); tick();
    check("rst_strobes", {27'b0, Ram1EN, Ram1OE, Ram1WE, rdn, wrn}, 32'h1F);
    check("rst_addr", 32'(Ram1Addr), 32'd0);
    check("rst_acks", {30'b0, if_ack, d_ack}, 32'd0);
    check("rst_rdata", {if_rdata, d_rdata}, 32'd0);
    check("rst_conflict", 32'(mem_conflict), 32'd0);
    if_req = 1'b0;
    rst    = 1'b0;
    tick();

    // Fetch only.
    access(1'b1, 1'b0, 16'h0040, 16'h0000, "fetch");

    // SRAM write then readback.
    access(1'b0, 1'b1, 16'h0100, 16'hBEEF, "sram_wr");
    access(1'b0, 1'b0, 16'h0100, 16'h0000, "sram_rb");

    // Contention: data read and fetch in the same cycle.
    if_req = 1'b1; if_addr = 16'h0040;
    d_req = 1'b1; d_we = 1'b0; d_addr = 16'h0200;
    #1;
    conf_bad = (mem_conflict !== 1'b1) ? 1 : 0;
    for (int k = 1; k <= 6; k++) begin
      tick();
      if (k == 2) begin
        check("cont_d_ack", {30'b0, d_ack, if_ack}, 32'd2);
        check("cont_d_rdata", 32'(d_rdata), 32'(ref_mem[16'h0200]));
        d_req = 1'b0;
      end
      if (k == 5) begin
        check("cont_if_ack", {30'b0, if_ack, d_ack}, 32'd2);
        check("cont_if_rdata", 32'(if_rdata), 32'h1234);
        if_req = 1'b0;
      end
      if (k < 5 && mem_conflict !== (k <= 3)) conf_bad++;
    end
    check("cont_conflict", 32'(conf_bad), 32'd0);

    // UART: status, data write, data read.
    tbre = 1'b1; tsre = 1'b1; data_ready = 1'b0;
    access(1'b0, 1'b0, Com1Cmd, 16'h0000, "status_rd");
    access(1'b0, 1'b1, Com1Data, 16'h0041, "uart_wr");
    uart_byte = 8'h5A;
    access(1'b0, 1'b0, Com1Data, 16'h0000, "uart_rd");

    // Reset in the middle of a write pulse drops the transaction.
    d_req = 1'b1; d_we = 1'b1; d_addr = 16'h0300; d_wdata = 16'h1111;
    tick(); tick();
    check("abort_in_pulse", 32'(Ram1WE), 32'd0);
    rst = 1'b1; d_req = 1'b0;
    tick();
    check("abort_strobes", {29'b0, Ram1EN, Ram1WE, wrn}, 32'h7);
    check("abort_no_ack", {30'b0, d_ack, if_ack}, 32'd0);
    check("abort_addr", 32'(Ram1Addr), 32'd0);
    rst = 1'b0;
    tick();
    check("abort_no_ack_after", {30'b0, d_ack, if_ack}, 32'd0);
    access(1'b0, 1'b1, 16'h0300, 16'h7E57, "reissue_wr");
    access(1'b0, 1'b0, 16'h0300, 16'h0000, "reissue_rb");

    // Random transactions against the model.
    for (int n = 0; n < 60; n++) begin
      r          = int'($urandom_range(0, 9));
      w          = 16'($urandom);
      uart_byte  = 8'($urandom);
      tbre       = 1'($urandom_range(0, 1));
      tsre       = 1'($urandom_range(0, 1));
      data_ready = 1'($urandom_range(0, 1));
      if (r <= 2) begin
        access(1'b1, 1'b0, 16'($urandom_range(0, 63)), w, "rnd_fetch");
      end else if (r <= 5) begin
        access(1'b0, 1'($urandom_range(0, 1)), 16'($urandom_range(0, 63)), w, "rnd_sram");
      end else if (r == 6) begin
        access(1'b0, 1'($urandom_range(0, 1)), Com1Data, w, "rnd_uart");
      end else if (r == 7) begin
        access(1'b0, 1'($urandom_range(0, 1)), Com1Cmd, w, "rnd_status");
      end else if (r == 8) begin
        if ($urandom_range(0, 1) == 0) a = 16'h8000 + 16'($urandom_range(0, 16'h3EFF));
        else                           a = 16'hBF02 + 16'($urandom_range(0, 16'h40FD));
        access(1'b0, 1'($urandom_range(0, 1)), a, w, "rnd_unmapped");
      end else begin
        access(1'b1, 1'b0, 16'($urandom), w, "rnd_fetch_hi");
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
